serial_subtractor_ctrl: RTL and testbench

- Bit-serial N-bit unsigned subtractor controller; computes `diff = a - b` and a final borrow.
- Reuses one 1-bit full-subtractor cell (built from two half subtractors) across WIDTH cycles, LSB first.
- A borrow flip-flop carries the borrow between cycles.
- Sits between a requester and a consumer with valid/ready handshakes on both sides; trades latency for area against a parallel ripple subtractor.

---
 rtl/serial_sub_pkg.sv | 5 +
 rtl/full_subtractor_bit.sv | 13 +
 rtl/half_subtractor_st.sv | 10 +
 rtl/serial_subtractor_ctrl.sv | 68 ++++++
 tb/tb_serial_subtractor_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM state encoding and default operand width for the bit-serial subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/full_subtractor_bit.sv
// full_subtractor_bit: 1-bit full subtractor from two half subtractors; ports a, b, bin -> d, bout
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic d1, b1, b2;
  half_subtractor_st u_h1 (.a(a), .b(b), .d(d1), .bout(b1));
  half_subtractor_st u_h2 (.a(d1), .b(bin), .d(d), .bout(b2));
  assign bout = b1 | b2;
endmodule

// File: rtl/half_subtractor_st.sv
// half_subtractor_st: 1-bit half subtractor; ports a, b -> d = a^b, bout = ~a&b
module half_subtractor_st (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);
  assign d = a ^ b;
  assign bout = ~a & b;
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: LSB-first bit-serial a-b with valid/ready on both sides; ports clk, rst, in_valid/in_ready/a_in/b_in, out_valid/out_ready/difference/borrow, busy; SERIAL_SUB_SAT_EN clamps underflowed results to zero
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] difference,
  output logic             borrow,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr, diff_q;
  logic [WIDTH-2:0] res;
  logic [CNT_W-1:0] cnt;
  logic bflop, bor_q, d, bout, last;
  full_subtractor_bit u_fs (.a(a_sr[0]), .b(b_sr[0]), .bin(bflop), .d(d), .bout(bout));
  assign last = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  always_comb
    state_n = (state == IDLE) ? (in_valid ? RUN : IDLE) :
              (state == RUN)  ? (last ? DONE : RUN) :
              (out_ready ? IDLE : DONE);
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      res <= '0;
      cnt <= '0;
      bflop <= 1'b0;
      bor_q <= 1'b0;
      diff_q <= '0;
    end else if (state == IDLE && in_valid) begin
      a_sr <= a_in;
      b_sr <= b_in;
      bflop <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      bflop <= bout;
      cnt <= cnt + CNT_W'(1);
      res <= (WIDTH - 1)'({d, res} >> 1);
      if (last) begin
        bor_q <= bout;
`ifdef SERIAL_SUB_SAT_EN
        diff_q <= bout ? '0 : {d, res};
`else
        diff_q <= {d, res};
`endif
      end
    end
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state == RUN;
  assign difference = diff_q;
  assign borrow = bor_q;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: directed vectors, backpressure and mid-run reset at WIDTH=8 plus exhaustive WIDTH=4 sweep
module tb_serial_subtractor_ctrl;
`ifdef SERIAL_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] raw;
    logic       bo;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv8 = 1'b0, ir8, ov8, or8 = 1'b0, bor8, busy8;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic iv4 = 1'b0, ir4, ov4, or4 = 1'b1, bor4, busy4;
  logic [3:0] a4 = '0, b4 = '0, diff4;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a_in(a8), .b_in(b8),
    .out_valid(ov8), .out_ready(or8), .difference(diff8), .borrow(bor8), .busy(busy8)
  );
  serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a_in(a4), .b_in(b4),
    .out_valid(ov4), .out_ready(or4), .difference(diff4), .borrow(bor4), .busy(busy4)
  );
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic op8(input logic [7:0] a, input logic [7:0] b, output logic [7:0] d, output logic bo, output int lat);
    int n;
    @(negedge clk);
    a8 = a;
    b8 = b;
    iv8 = 1'b1;
    n = 0;
    while (!ir8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    iv8 = 1'b0;
    a8 = ~a;
    b8 = ~b;
    while (!ov8 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    d = diff8;
    bo = bor8;
    or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or8 = 1'b0;
  endtask
  initial begin
    vec_t vecs[6];
    logic [7:0] d;
    logic bo;
    int lat, n;
    logic [4:0] r4;
    vecs[0] = '{8'h35, 8'h12, 8'h23, 1'b0};
    vecs[1] = '{8'h12, 8'h35, 8'hDD, 1'b1};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h00, 8'h80, 1'b0};
    vecs[5] = '{8'hC3, 8'h3C, 8'h87, 1'b0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", ir8, 1);
    check("reset out_valid", ov8, 0);
    check("reset busy", busy8, 0);
    check("reset difference", diff8, 0);
    check("reset borrow", bor8, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      op8(vecs[i].a, vecs[i].b, d, bo, lat);
      check($sformatf("vec%0d difference", i), d, (SAT && vecs[i].bo) ? 8'h00 : vecs[i].raw);
      check($sformatf("vec%0d borrow", i), bo, vecs[i].bo);
      check($sformatf("vec%0d latency", i), lat, 8);
      check($sformatf("vec%0d idle after", i), ir8, 1);
    end
    @(negedge clk);
    a8 = 8'h50;
    b8 = 8'h20;
    iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    check("run busy", busy8, 1);
    check("run in_ready", ir8, 0);
    n = 0;
    while (!ov8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("bp out_valid seen", ov8, 1);
    for (int c = 0; c < 5; c++) begin
      iv8 = c[0];
      a8 = 8'h01;
      b8 = 8'h02;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp%0d out_valid", c), ov8, 1);
      check($sformatf("bp%0d difference", c), diff8, 8'h30);
      check($sformatf("bp%0d borrow", c), bor8, 0);
      check($sformatf("bp%0d in_ready", c), ir8, 0);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or8 = 1'b0;
    check("bp release in_ready", ir8, 1);
    check("bp release out_valid", ov8, 0);
    check("bp release difference held", diff8, 8'h30);
    @(negedge clk);
    check("bp no stray accept", busy8, 0);
    a8 = 8'h77;
    b8 = 8'h11;
    iv8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("mid-run busy", busy8, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort in_ready", ir8, 1);
    check("abort busy", busy8, 0);
    check("abort out_valid", ov8, 0);
    check("abort difference", diff8, 0);
    repeat (10) begin
      @(negedge clk);
      if (ov8) check("abort stray out_valid", ov8, 0);
    end
    op8(8'h0A, 8'h03, d, bo, lat);
    check("post-abort difference", d, 8'h07);
    check("post-abort borrow", bo, 0);
    check("post-abort latency", lat, 8);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        a4 = 4'(a);
        b4 = 4'(b);
        iv4 = 1'b1;
        n = 0;
        while (!ir4 && n < 20) begin
          @(negedge clk);
          n++;
        end
        @(posedge clk);
        @(negedge clk);
        iv4 = 1'b0;
        n = 0;
        while (!ov4 && n < 20) begin
          @(negedge clk);
          n++;
        end
        r4 = {1'b0, 4'(a)} - {1'b0, 4'(b)};
        check($sformatf("sweep %0h-%0h", a, b), {ov4, bor4, diff4},
              {1'b1, r4[4], (SAT && r4[4]) ? 4'h0 : r4[3:0]});
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
